// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory stage of the 24-bit pipeline.
// Used by mem_access_stage and its MEM/WB register mem_wb_reg.
package mem_access_stage_pkg;

    localparam int DATA_W = 24;
    localparam int DEST_W = 4;
    localparam int ADDR_W = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic              wb_valid;
        logic              writeback_enable;
        logic              mem_read_enable;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] mem_read_data;
        logic [DATA_W-1:0] alu_result;
    } mem_wb_t;

    // A bubble kills the control bits but keeps the data fields unchanged.
    function automatic mem_wb_t make_bubble(input mem_wb_t prev);
        mem_wb_t b;
        b                  = prev;
        b.wb_valid         = 1'b0;
        b.writeback_enable = 1'b0;
        b.mem_read_enable  = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register: loads a retiring instruction or inserts a bubble.
module mem_wb_reg
    import mem_access_stage_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  mem_wb_t d,
    output mem_wb_t q
);

    mem_wb_t q_r;

    // Pipeline register with synchronous reset and bubble insertion.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= '0;
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= make_bubble(q_r);
        end
    end

    assign q = q_r;

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues loads/stores over a req/ack handshake and fills MEM/WB.
// Optional macro MEM_STALL_CNT_EN adds a saturating 16-bit stall_count output.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              writeback_enable,
    input  logic              mem_read_enable,
    input  logic              mem_write_enable,
    input  logic [DEST_W-1:0] instruction_dest,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
`ifdef MEM_STALL_CNT_EN
    output logic [15:0]       stall_count,
`endif
    output logic              wb_valid_out,
    output logic              writeback_enable_out,
    output logic              mem_read_enable_out,
    output logic [DEST_W-1:0] instruction_dest_out,
    output logic [DATA_W-1:0] mem_read_data_out,
    output logic [DATA_W-1:0] alu_result_out
);

    mem_state_t        state_r;
    mem_state_t        state_nxt_s;
    logic              dmem_req_r;
    logic              hold_wbe_r;
    logic              hold_mre_r;
    logic              hold_we_r;
    logic [DEST_W-1:0] hold_dest_r;
    logic [DATA_W-1:0] hold_alu_r;
    logic [DATA_W-1:0] hold_wdata_r;
    logic              access_s;
    logic              accept_s;
    logic              wb_load_s;
    mem_wb_t           wb_d_s;
    mem_wb_t           wb_q_s;

    assign access_s = mem_read_enable | mem_write_enable;
    assign accept_s = (state_r == IDLE) & ex_valid & access_s;

    // Next-state decode and selection of the entry retiring into MEM/WB.
    always_comb begin
        state_nxt_s = state_r;
        wb_load_s   = 1'b0;
        wb_d_s      = '0;
        case (state_r)
            IDLE: begin
                if (ex_valid && access_s) begin
                    state_nxt_s = BUSY;
                end else if (ex_valid) begin
                    wb_load_s               = 1'b1;
                    wb_d_s.wb_valid         = 1'b1;
                    wb_d_s.writeback_enable = writeback_enable;
                    wb_d_s.mem_read_enable  = mem_read_enable;
                    wb_d_s.dest             = instruction_dest;
                    wb_d_s.mem_read_data    = {DATA_W{1'b0}};
                    wb_d_s.alu_result       = alu_result;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_nxt_s             = IDLE;
                    wb_load_s               = 1'b1;
                    wb_d_s.wb_valid         = 1'b1;
                    wb_d_s.writeback_enable = hold_wbe_r;
                    wb_d_s.mem_read_enable  = hold_mre_r;
                    wb_d_s.dest             = hold_dest_r;
                    wb_d_s.mem_read_data    = hold_mre_r ? dmem_rdata : {DATA_W{1'b0}};
                    wb_d_s.alu_result       = hold_alu_r;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, request flag and hold registers; a load wins over a simultaneous store.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            dmem_req_r   <= 1'b0;
            hold_wbe_r   <= 1'b0;
            hold_mre_r   <= 1'b0;
            hold_we_r    <= 1'b0;
            hold_dest_r  <= {DEST_W{1'b0}};
            hold_alu_r   <= {DATA_W{1'b0}};
            hold_wdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            dmem_req_r <= (state_nxt_s == BUSY);
            if (accept_s) begin
                hold_wbe_r   <= writeback_enable;
                hold_mre_r   <= mem_read_enable;
                hold_we_r    <= mem_write_enable & ~mem_read_enable;
                hold_dest_r  <= instruction_dest;
                hold_alu_r   <= alu_result;
                hold_wdata_r <= store_data;
            end
        end
    end

`ifdef MEM_STALL_CNT_EN
    logic [15:0] stall_count_r;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_r <= 16'h0000;
        end else if (mem_stall && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'h0001;
        end
    end

    assign stall_count = stall_count_r;
`endif

    mem_wb_reg u_mem_wb_reg (
        .clk  (clk),
        .rst  (rst),
        .load (wb_load_s),
        .d    (wb_d_s),
        .q    (wb_q_s)
    );

    assign mem_stall            = (state_r == BUSY);
    assign dmem_req             = dmem_req_r;
    assign dmem_we              = hold_we_r;
    assign dmem_addr            = hold_alu_r[ADDR_W-1:0];
    assign dmem_wdata           = hold_wdata_r;
    assign wb_valid_out         = wb_q_s.wb_valid;
    assign writeback_enable_out = wb_q_s.writeback_enable;
    assign mem_read_enable_out  = wb_q_s.mem_read_enable;
    assign instruction_dest_out = wb_q_s.dest;
    assign mem_read_data_out    = wb_q_s.mem_read_data;
    assign alu_result_out       = wb_q_s.alu_result;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus random traffic
// against a transaction-level model with its own word-addressed memory.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        writeback_enable;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [3:0]  instruction_dest;
    logic [23:0] alu_result;
    logic [23:0] store_data;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [9:0]  dmem_addr;
    logic [23:0] dmem_wdata;
    logic [23:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid_out;
    logic        writeback_enable_out;
    logic        mem_read_enable_out;
    logic [3:0]  instruction_dest_out;
    logic [23:0] mem_read_data_out;
    logic [23:0] alu_result_out;
`ifdef MEM_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int          checks = 0;
    int          fails  = 0;
    logic [23:0] mem_model [1024];
    logic [3:0]  last_dest;
    logic [23:0] last_rdata;
    logic [23:0] last_alu;
    int          stall_exp;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .ex_valid             (ex_valid),
        .writeback_enable     (writeback_enable),
        .mem_read_enable      (mem_read_enable),
        .mem_write_enable     (mem_write_enable),
        .instruction_dest     (instruction_dest),
        .alu_result           (alu_result),
        .store_data           (store_data),
        .mem_stall            (mem_stall),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_wdata           (dmem_wdata),
        .dmem_rdata           (dmem_rdata),
        .dmem_ack             (dmem_ack),
`ifdef MEM_STALL_CNT_EN
        .stall_count          (stall_count),
`endif
        .wb_valid_out         (wb_valid_out),
        .writeback_enable_out (writeback_enable_out),
        .mem_read_enable_out  (mem_read_enable_out),
        .instruction_dest_out (instruction_dest_out),
        .mem_read_data_out    (mem_read_data_out),
        .alu_result_out       (alu_result_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_retired(input bit wbe, input bit re, input logic [3:0] dest,
                               input logic [23:0] rd, input logic [23:0] alu);
        chk("ret_valid", {31'd0, wb_valid_out}, 32'd1);
        chk("ret_wbe", {31'd0, writeback_enable_out}, {31'd0, wbe});
        chk("ret_mre", {31'd0, mem_read_enable_out}, {31'd0, re});
        chk("ret_dest", {28'd0, instruction_dest_out}, {28'd0, dest});
        chk("ret_rdata", {8'd0, mem_read_data_out}, {8'd0, rd});
        chk("ret_alu", {8'd0, alu_result_out}, {8'd0, alu});
        chk("ret_req", {31'd0, dmem_req}, 32'd0);
        chk("ret_stall", {31'd0, mem_stall}, 32'd0);
        last_dest  = dest;
        last_rdata = rd;
        last_alu   = alu;
    endtask

    task automatic chk_bubble();
        chk("bub_valid", {31'd0, wb_valid_out}, 32'd0);
        chk("bub_wbe", {31'd0, writeback_enable_out}, 32'd0);
        chk("bub_mre", {31'd0, mem_read_enable_out}, 32'd0);
        chk("bub_dest", {28'd0, instruction_dest_out}, {28'd0, last_dest});
        chk("bub_rdata", {8'd0, mem_read_data_out}, {8'd0, last_rdata});
        chk("bub_alu", {8'd0, alu_result_out}, {8'd0, last_alu});
    endtask

    // Present one instruction, play memory with the given ack latency, check retirement.
    task automatic issue(input bit re, input bit wr, input bit wbe, input logic [3:0] dest,
                         input logic [23:0] alu, input logic [23:0] sd, input int lat);
        logic [9:0]  a;
        logic [23:0] exp_rd;
        bit          is_wr;
        a     = alu[9:0];
        is_wr = wr & ~re;
        exp_rd = 24'd0;
        ex_valid = 1'b1; mem_read_enable = re; mem_write_enable = wr;
        writeback_enable = wbe; instruction_dest = dest; alu_result = alu; store_data = sd;
        dmem_ack = 1'b0;
        tick();
        ex_valid = 1'b0;
        if (re || wr) begin
            if (re) exp_rd = mem_model[a];
            for (int c = 1; c <= lat; c++) begin
                chk("busy_wb_valid", {31'd0, wb_valid_out}, 32'd0);
                chk("busy_stall", {31'd0, mem_stall}, 32'd1);
                chk("busy_req", {31'd0, dmem_req}, 32'd1);
                chk("busy_we", {31'd0, dmem_we}, {31'd0, is_wr});
                chk("busy_addr", {22'd0, dmem_addr}, {22'd0, a});
                if (is_wr) chk("busy_wdata", {8'd0, dmem_wdata}, {8'd0, sd});
                dmem_ack   = (c == lat);
                dmem_rdata = (c == lat) ? mem_model[a] : 24'($urandom);
                tick();
            end
            dmem_ack   = 1'b0;
            dmem_rdata = 24'($urandom);
            if (is_wr) mem_model[a] = sd;
            stall_exp += lat;
        end
        chk_retired(wbe, re, dest, exp_rd, alu);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; writeback_enable = 1'b0; mem_read_enable = 1'b0;
        mem_write_enable = 1'b0; instruction_dest = 4'd0; alu_result = 24'd0;
        store_data = 24'd0; dmem_rdata = 24'd0; dmem_ack = 1'b0;
        for (int i = 0; i < 1024; i++) mem_model[i] = 24'($urandom);
        mem_model[5] = 24'h000002;
        last_dest = 4'd0; last_rdata = 24'd0; last_alu = 24'd0; stall_exp = 0;
        tick();
        tick();
        rst = 1'b0;
        // Reset state
        chk("rst_valid", {31'd0, wb_valid_out}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_addr", {22'd0, dmem_addr}, 32'd0);
        chk("rst_alu", {8'd0, alu_result_out}, 32'd0);
`ifdef MEM_STALL_CNT_EN
        chk("rst_stall_count", {16'd0, stall_count}, 32'd0);
`endif

        // Directed: ALU op, two loads with 3-cycle acks, a store, then an idle bubble
        issue(1'b0, 1'b0, 1'b1, 4'd1, 24'h000001, 24'h000000, 0);
        issue(1'b1, 1'b0, 1'b1, 4'd2, 24'h000005, 24'h000000, 3);
        issue(1'b1, 1'b0, 1'b1, 4'd2, 24'h000005, 24'h000000, 3);
`ifdef MEM_STALL_CNT_EN
        chk("two_loads_stall_count", {16'd0, stall_count}, 32'd6);
`endif
        issue(1'b0, 1'b1, 1'b0, 4'd3, 24'h000007, 24'hABCDEF, 2);
        tick();
        chk_bubble();

        // Back-to-back: load then an ALU op held upstream during BUSY
        mem_model[9] = 24'h123456;
        ex_valid = 1'b1; mem_read_enable = 1'b1; mem_write_enable = 1'b0;
        writeback_enable = 1'b1; instruction_dest = 4'd4; alu_result = 24'h000009;
        tick();
        mem_read_enable = 1'b0; instruction_dest = 4'd6; alu_result = 24'h0000AA;
        chk("b2b_stall1", {31'd0, mem_stall}, 32'd1);
        tick();
        dmem_ack = 1'b1; dmem_rdata = mem_model[9];
        tick();
        dmem_ack = 1'b0; dmem_rdata = 24'($urandom);
        stall_exp += 2;
        chk_retired(1'b1, 1'b1, 4'd4, 24'h123456, 24'h000009);
        tick();
        ex_valid = 1'b0;
        chk_retired(1'b1, 1'b0, 4'd6, 24'h000000, 24'h0000AA);
        tick();
        chk_bubble();

        // Random traffic over a small address window so loads see earlier stores
        for (int n = 0; n < 40; n++) begin
            int  kind;
            kind = int'($urandom_range(0, 4));
            if (kind == 4) begin
                tick();
                chk_bubble();
            end else begin
                issue(kind == 1 || kind == 3, kind == 2 || kind == 3, 1'($urandom),
                      4'($urandom), {14'($urandom), 6'd0, 4'($urandom)}, 24'($urandom),
                      int'($urandom_range(1, 4)));
            end
        end
`ifdef MEM_STALL_CNT_EN
        chk("rand_stall_count", {16'd0, stall_count}, stall_exp);
`endif

        // Reset while BUSY, then a late ack that must be ignored
        ex_valid = 1'b1; mem_read_enable = 1'b1; mem_write_enable = 1'b0;
        writeback_enable = 1'b1; instruction_dest = 4'd9; alu_result = 24'h000033;
        tick();
        ex_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_dest = 4'd0; last_rdata = 24'd0; last_alu = 24'd0;
        chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("mid_rst_we", {31'd0, dmem_we}, 32'd0);
        chk("mid_rst_addr", {22'd0, dmem_addr}, 32'd0);
        chk("mid_rst_wdata", {8'd0, dmem_wdata}, 32'd0);
        chk_bubble();
        dmem_ack = 1'b1; dmem_rdata = 24'h5A5A5A;
        tick();
        dmem_ack = 1'b0;
        chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
        chk("late_ack_stall", {31'd0, mem_stall}, 32'd0);
        chk_bubble();
`ifdef MEM_STALL_CNT_EN
        chk("mid_rst_stall_count", {16'd0, stall_count}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 24-bit pipeline. Sits between the EX/MEM boundary and writeback_stage.
- Issues loads and stores to a variable-latency data memory over a req/ack handshake.
- Stalls upstream while an access is outstanding.
- Registers the MEM/WB fields consumed by writeback_stage: writeback_enable, mem_read_enable, instruction_dest, mem_read_data, alu_result.

Parameters:
- DATA_W, 24, datapath width. Must match writeback_stage.
- DEST_W, 4, register-index width (16 registers).
- ADDR_W, 10, data-memory word-address width. dmem_addr = alu_result[ADDR_W-1:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX/MEM holds a valid instruction.
- writeback_enable  in  1  instruction writes the register file.
- mem_read_enable  in  1  instruction is a load.
- mem_write_enable  in  1  instruction is a store.
- instruction_dest  in  DEST_W  destination register.
- alu_result  in  DATA_W  ALU result, or effective address for loads/stores.
- store_data  in  DATA_W  store operand.
- mem_stall  out  1  upstream must hold EX/MEM contents.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  ADDR_W  word address.
- dmem_wdata  out  DATA_W  write data.
- dmem_rdata  in  DATA_W  read data, valid when dmem_ack = 1.
- dmem_ack  in  1  one-cycle completion pulse.
- wb_valid_out  out  1  MEM/WB slot holds a retired instruction.
- writeback_enable_out  out  1  to writeback_stage.writeback_enable.
- mem_read_enable_out  out  1  to writeback_stage.mem_read_enable.
- instruction_dest_out  out  DEST_W  to writeback_stage.instruction_dest.
- mem_read_data_out  out  DATA_W  to writeback_stage.mem_read_data.
- alu_result_out  out  DATA_W  to writeback_stage.alu_result.

Behaviour:
- Reset: all registered outputs 0, state IDLE. Applies in the cycle after the rst edge, including mid-access: the outstanding request is abandoned and dmem_req drops. A late dmem_ack in IDLE is ignored.
- FSM has two states, IDLE and BUSY.
- IDLE, ex_valid = 0:
  - MEM/WB gets a bubble: wb_valid_out = 0, writeback_enable_out = 0, mem_read_enable_out = 0.
  - Data fields hold their previous values.
- IDLE, ex_valid = 1 and neither read nor write:
  - All fields pass to MEM/WB next cycle; wb_valid_out = 1; mem_read_data_out = 0.
  - Latency is 1 cycle.
- IDLE, ex_valid = 1 and (read or write):
  - Capture writeback_enable, mem_read_enable, instruction_dest, alu_result, store_data and the access type into hold registers.
  - Go to BUSY; the next MEM/WB slot is a bubble.
- Read and write both set: treated as a read; the write is suppressed.
- BUSY:
  - dmem_req = 1 (registered), with dmem_we/dmem_addr/dmem_wdata driven from the hold registers. Held stable until dmem_ack.
  - mem_stall = 1 for the whole BUSY state, including the ack cycle.
  - MEM/WB gets bubbles while waiting.
- BUSY, on dmem_ack:
  - Next cycle: dmem_req = 0, state IDLE.
  - MEM/WB loads the held fields with wb_valid_out = 1.
  - Loads: mem_read_data_out = dmem_rdata sampled in the ack cycle.
  - Stores: mem_read_data_out = 0.
  - Total load latency = ack latency + 1 cycle after capture.
- Back-to-back: the instruction held upstream during BUSY is accepted in the first IDLE cycle after ack. No instruction is lost or duplicated.
- mem_stall is 0 in IDLE.

Optional Feature:
- Macro: MEM_STALL_CNT_EN.
- Defined:
  - Adds output stall_count, 16 bits.
  - Increments every cycle mem_stall = 1; saturates at 0xFFFF; cleared by rst.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package: DATA_W, DEST_W, ADDR_W constants; mem_state_t enum {IDLE, BUSY}; packed mem_wb_t struct (wb_valid, writeback_enable, mem_read_enable, dest, mem_read_data, alu_result).
- One sub-module, mem_wb_reg: the MEM/WB pipeline register with bubble insert and synchronous reset. FSM and hold registers stay in the top.

Test Plan:
- ALU op: ex_valid = 1, writeback_enable = 1, dest = 1, alu_result = 1 -> next cycle wb_valid_out = 1, dest_out = 1, alu_result_out = 1, no dmem_req.
- Load, ack after 3 cycles: alu_result = 0x000005, dest = 2, dmem_rdata = 0x000002 -> dmem_addr = 5 and mem_stall = 1 for 3 cycles; then mem_read_enable_out = 1, mem_read_data_out = 2, dest_out = 2.
- Store: store_data = 0xABCDEF, alu_result = 7 -> dmem_we = 1, addr = 7, wdata = 0xABCDEF held until ack; then wb_valid_out = 1, writeback_enable_out = 0.
- Back-to-back: load followed by ALU op -> ALU op retires exactly one cycle after the load's MEM/WB slot, no duplicate.
- Reset while BUSY before ack -> next cycle dmem_req = 0, all outputs 0; a following ack is ignored.
- MEM_STALL_CNT_EN defined: two loads with 3-cycle acks -> stall_count = 6.
